// File: rtl/dac_spi_pkg.sv
// Shared types and helpers for the converter configuration SPI master.
package dac_spi_pkg;

    typedef enum logic [2:0] {IDLE, INSTR, WR, RD, GAP} state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Bits in one frame: instruction {rw, addr} plus (len+1) data bytes.
    function automatic int frame_bits(input int addr_w, input int len);
        return addr_w + 1 + 8 * (len + 1);
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Bit-period counter: SCLK low for the first half, high for the second half,
// with strobes marking bit start, rising edge and last cycle of each bit.
module spi_sclk_gen #(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    output logic bit_start,
    output logic sclk_rise,
    output logic bit_end,
    output logic sclk
);

    localparam int HALF = CLK_DIV / 2;
    localparam int CW   = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (!en || cnt == CW'(CLK_DIV - 1))
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign bit_start = en && (cnt == '0);
    assign sclk_rise = en && (cnt == CW'(HALF));
    assign bit_end   = en && (cnt == CW'(CLK_DIV - 1));
    assign sclk      = en && (cnt >= CW'(HALF));

endmodule

// File: rtl/dac_spi_master.sv
// SPI master for converter configuration ports: valid/ready command in,
// one instruction word plus a burst of data bytes out, optional 3-wire readback.
module dac_spi_master
    import dac_spi_pkg::*;
#(
    parameter int ADDR_W     = 7,
    parameter int NBYTES_MAX = 4,
    parameter int CLK_DIV    = 10,
    parameter int THREE_WIRE = 1,
    localparam int LEN_W     = (NBYTES_MAX > 1) ? $clog2(NBYTES_MAX) : 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_rw,
    input  logic [ADDR_W-1:0]       cmd_addr,
    input  logic [LEN_W-1:0]        cmd_len,
    input  logic [8*NBYTES_MAX-1:0] cmd_wdata,
    output logic                    rsp_valid,
    output logic [8*NBYTES_MAX-1:0] rsp_rdata,
    output logic                    spi_sclk,
    output logic                    spi_csb,
    inout  wire                     spi_sdio,
    input  logic                    spi_sdo
);

    localparam int DW   = 8 * NBYTES_MAX;
    localparam int TX_W = frame_bits(ADDR_W, NBYTES_MAX - 1);
    localparam int BCW  = $clog2(((TX_W > CLK_DIV) ? TX_W : CLK_DIV) + 1);

    if (CLK_DIV < 4 || (CLK_DIV % 2) != 0) begin : g_bad_div
        $error("dac_spi_master: CLK_DIV must be even and >= 4");
    end

    state_t           state, state_nx;
    logic [BCW-1:0]   bit_cnt;
    logic [LEN_W-1:0] len_q, len_clamped;
    logic             rw_q;
    logic [TX_W-1:0]  tx_sr, tx_load;
    logic [7:0]       rx_byte;
    logic [DW-1:0]    rdata_acc, rx_ext;
    logic             sclk_en, bit_start, sclk_rise, bit_end;
    logic             accept, instr_last, data_last, gap_last;
    logic             oe, sdo_bit, rd_line;

    // Out-of-range lengths saturate at the longest burst.
    if ((1 << LEN_W) > NBYTES_MAX) begin : g_clamp
        assign len_clamped = (cmd_len > LEN_W'(NBYTES_MAX - 1)) ? LEN_W'(NBYTES_MAX - 1) : cmd_len;
    end else begin : g_noclamp
        assign len_clamped = cmd_len;
    end

    assign accept     = cmd_valid && (state == IDLE);
    assign instr_last = (bit_cnt == BCW'(ADDR_W));
    assign data_last  = (bit_cnt == BCW'({len_q, 3'b111}));
    assign gap_last   = (bit_cnt == BCW'(CLK_DIV - 1));
    assign sclk_en    = (state == INSTR) || (state == WR) || (state == RD);
    assign rx_ext     = DW'(rx_byte) << {bit_cnt[BCW-1:3], 3'b000};

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk       (clk),
        .rstn      (rstn),
        .en        (sclk_en),
        .bit_start (bit_start),
        .sclk_rise (sclk_rise),
        .bit_end   (bit_end),
        .sclk      (spi_sclk)
    );

    // Whole frame is preloaded MSB-first; reads carry zeros in the data slots.
    always_comb begin
        tx_load = '0;
        tx_load[TX_W-1 -: ADDR_W+1] = {cmd_rw, cmd_addr};
        if (cmd_rw == RW_WRITE) begin
            for (int k = 0; k < NBYTES_MAX; k++)
                tx_load[TX_W-1-(ADDR_W+1)-8*k -: 8] = cmd_wdata[8*k +: 8];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = INSTR;
            INSTR:   if (bit_end && instr_last) state_nx = (rw_q == RW_READ) ? RD : WR;
            WR, RD:  if (bit_end && data_last) state_nx = GAP;
            GAP:     if (gap_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt   <= '0;
            len_q     <= '0;
            rw_q      <= 1'b0;
            tx_sr     <= '0;
            rx_byte   <= '0;
            rdata_acc <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (accept) begin
                        rw_q      <= cmd_rw;
                        len_q     <= len_clamped;
                        tx_sr     <= tx_load;
                        rdata_acc <= '0;
                    end
                end
                INSTR: begin
                    if (bit_end) begin
                        tx_sr   <= tx_sr << 1;
                        bit_cnt <= instr_last ? '0 : bit_cnt + BCW'(1);
                    end
                end
                WR, RD: begin
                    if (state == RD && bit_start && bit_cnt[2:0] == 3'd0)
                        rx_byte <= '0;
                    if (state == RD && sclk_rise)
                        rx_byte <= {rx_byte[6:0], rd_line};
                    if (bit_end) begin
                        tx_sr   <= tx_sr << 1;
                        bit_cnt <= data_last ? '0 : bit_cnt + BCW'(1);
                        if (state == RD && bit_cnt[2:0] == 3'd7)
                            rdata_acc <= rdata_acc | rx_ext;
                        // Last byte is merged on the fly so rdata is ready with the pulse.
                        if (data_last) begin
                            rsp_valid <= 1'b1;
                            if (state == RD)
                                rsp_rdata <= rdata_acc | rx_ext;
                        end
                    end
                end
                GAP: bit_cnt <= gap_last ? '0 : bit_cnt + BCW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        case (state)
            INSTR, WR: oe = 1'b1;
            RD:        oe = (THREE_WIRE == 0);
            default:   oe = 1'b0;
        endcase
    end

    assign sdo_bit   = (state == RD) ? 1'b0 : tx_sr[TX_W-1];
    assign spi_sdio  = oe ? sdo_bit : 1'bz;
    assign rd_line   = (THREE_WIRE != 0) ? spi_sdio : spi_sdo;
    assign spi_csb   = (state == IDLE) || (state == GAP);
    assign cmd_ready = (state == IDLE);

endmodule

// File: tb/tb_dac_spi_master.sv
// Bench for dac_spi_master: SPI slave models, scoreboard of expected frames,
// 3-wire instance for the main table and a 4-wire instance for readback.
module tb_dac_spi_master;
    import dac_spi_pkg::*;

    localparam int CLK_DIV = 10;
    localparam int HALF    = CLK_DIV / 2;

    typedef struct {
        bit          rw;
        logic [6:0]  addr;
        logic [1:0]  len;
        logic [31:0] wdata;
        logic [31:0] sdata;
    } vec_t;

    typedef struct {
        logic [63:0] bits;
        int          nbits;
        logic [31:0] rdata;
        bit          rd;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // 3-wire instance
    logic        a_valid = 0, a_ready, a_rw = 0, a_rsp_valid, a_sclk, a_csb;
    logic [6:0]  a_addr = 0;
    logic [1:0]  a_len = 0;
    logic [31:0] a_wdata = 0, a_rdata;
    logic        a_sdo = 1'b0;
    wire         a_sdio;
    pullup (a_sdio);

    dac_spi_master #(.ADDR_W(7), .NBYTES_MAX(4), .CLK_DIV(CLK_DIV), .THREE_WIRE(1)) dut_a (
        .clk(clk), .rstn(rstn), .cmd_valid(a_valid), .cmd_ready(a_ready), .cmd_rw(a_rw),
        .cmd_addr(a_addr), .cmd_len(a_len), .cmd_wdata(a_wdata), .rsp_valid(a_rsp_valid),
        .rsp_rdata(a_rdata), .spi_sclk(a_sclk), .spi_csb(a_csb), .spi_sdio(a_sdio), .spi_sdo(a_sdo)
    );

    // 4-wire instance
    logic        b_valid = 0, b_ready, b_rw = 0, b_rsp_valid, b_sclk, b_csb;
    logic [6:0]  b_addr = 0;
    logic [1:0]  b_len = 0;
    logic [31:0] b_wdata = 0, b_rdata;
    logic        b_sdo = 1'b0;
    wire         b_sdio;
    pullup (b_sdio);

    dac_spi_master #(.ADDR_W(7), .NBYTES_MAX(4), .CLK_DIV(CLK_DIV), .THREE_WIRE(0)) dut_b (
        .clk(clk), .rstn(rstn), .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_rw(b_rw),
        .cmd_addr(b_addr), .cmd_len(b_len), .cmd_wdata(b_wdata), .rsp_valid(b_rsp_valid),
        .rsp_rdata(b_rdata), .spi_sclk(b_sclk), .spi_csb(b_csb), .spi_sdio(b_sdio), .spi_sdo(b_sdo)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- slave A (3-wire) ----------------
    int          s_rises = 0, s_falls = 0;
    logic [63:0] s_rx = 0;
    logic        s_rw = 0, s_oe = 0, s_bit = 0;
    logic [31:0] s_data = 0;

    assign a_sdio = (s_oe && !a_csb) ? s_bit : 1'bz;

    always @(negedge a_csb) begin
        s_rises = 0; s_falls = 0; s_rx = 0; s_oe = 0;
    end
    always @(posedge a_csb) s_oe = 0;
    always @(posedge a_sclk) if (!a_csb) begin
        s_rx = {s_rx[62:0], a_sdio};
        if (s_rises == 0) s_rw = a_sdio;
        s_rises++;
    end
    always @(negedge a_sclk) if (!a_csb) begin
        int d;
        s_falls++;
        d = s_falls - 8;
        if (s_rw && d >= 0 && d < 32) begin
            s_oe  = 1'b1;
            s_bit = s_data[8*(d/8) + 7 - (d%8)];
        end
    end

    // ---------------- slave B (4-wire) ----------------
    int          b_rises = 0, b_falls = 0, b_bad = 0;
    logic [63:0] b_rx = 0;
    logic [31:0] b_sdata = 32'h0000EFBE;

    always @(negedge b_csb) begin
        b_rises = 0; b_falls = 0; b_rx = 0;
    end
    always @(posedge b_sclk) if (!b_csb) begin
        b_rx = {b_rx[62:0], b_sdio};
        b_rises++;
    end
    always @(negedge b_sclk) if (!b_csb) begin
        int d;
        b_falls++;
        d = b_falls - 8;
        if (d >= 0 && d < 32) b_sdo = b_sdata[8*(d/8) + 7 - (d%8)];
    end
    always @(negedge clk) if (!b_csb && b_falls >= 8 && b_sdio !== 1'b0) b_bad++;

    // ---------------- scoreboard / monitor for A ----------------
    exp_t        sb[$];
    exp_t        mon_e;
    int          low_cnt = 0, hi_cnt = 0, oe_bad = 0, frames = 0, rsps = 0, since_rise = 0;
    bit          first_seen = 0, have_rise = 0, btb_mode = 0;
    logic        csb_prev = 1'b1, rdy_prev = 1'b1, exp_oe;
    logic [31:0] last_rdata = 0;
    logic [63:0] mask;

    always @(negedge clk) begin
        if (!a_csb && csb_prev) begin
            if (btb_mode) chk("btb_csb_high", hi_cnt, CLK_DIV + 1);
            frames++; low_cnt = 0; hi_cnt = 0; first_seen = 0; oe_bad = 0;
        end
        if (a_csb) hi_cnt++;
        else begin
            low_cnt++;
            if (a_sclk && !first_seen) begin
                chk("first_sclk_rise", low_cnt, HALF + 1);
                first_seen = 1;
            end
        end
        exp_oe = !a_csb && !(s_rw && s_falls >= 8);
        if (dut_a.oe !== exp_oe) oe_bad++;
        if (a_rsp_valid) begin
            rsps++;
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                mask  = (64'd1 << mon_e.nbits) - 64'd1;
                chk("csb_at_rsp", a_csb, 1);
                chk("sclk_rises", s_rises, mon_e.nbits);
                chk("frame_bits", s_rx & mask, mon_e.bits);
                chk("csb_low_cycles", low_cnt, mon_e.nbits * CLK_DIV);
                chk("oe_profile_errs", oe_bad, 0);
                if (mon_e.rd) begin
                    chk("rsp_rdata", a_rdata, mon_e.rdata);
                    last_rdata = mon_e.rdata;
                end else
                    chk("rdata_hold", a_rdata, last_rdata);
            end
            have_rise = 1; since_rise = 0;
        end else if (have_rise) begin
            since_rise++;
            if (a_ready && !rdy_prev) begin
                chk("ready_delay", since_rise, CLK_DIV);
                have_rise = 0;
            end
        end
        csb_prev = a_csb;
        rdy_prev = a_ready;
    end

    function automatic exp_t make_exp(input vec_t v);
        exp_t e;
        int nb;
        nb = int'(v.len) + 1;
        e.bits  = {56'd0, v.rw, v.addr};
        e.rdata = '0;
        for (int k = 0; k < nb; k++) begin
            e.bits = (e.bits << 8) | {56'd0, (v.rw ? v.sdata[8*k +: 8] : v.wdata[8*k +: 8])};
            if (v.rw) e.rdata[8*k +: 8] = v.sdata[8*k +: 8];
        end
        e.nbits = 8 + 8 * nb;
        e.rd    = v.rw;
        return e;
    endfunction

    task automatic issue(input vec_t v, input bit hold);
        int n;
        sb.push_back(make_exp(v));
        s_data = v.sdata;
        @(negedge clk);
        a_rw = v.rw; a_addr = v.addr; a_len = v.len; a_wdata = v.wdata; a_valid = 1'b1;
        n = 0;
        while (!a_ready && n < 1000) begin @(negedge clk); n++; end
        if (n >= 1000) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: got cmd_ready=0 expected 1 within 1000 cycles");
        end
        @(posedge clk); #1;
        if (!hold) a_valid = 1'b0;
        // Scramble fields to prove they were captured at acceptance.
        a_rw = ~v.rw; a_addr = ~v.addr; a_len = ~v.len; a_wdata = ~v.wdata;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || !a_ready) && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) begin
            n_cmp++; n_err++;
            $display("FAIL idle_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    vec_t vecs[6];
    vec_t v;
    int   f0, r0, n;

    initial begin
        vecs[0] = '{rw:1'b0, addr:7'h1F, len:2'd0, wdata:32'hFFFFFFA5, sdata:32'h0};
        vecs[1] = '{rw:1'b1, addr:7'h7F, len:2'd0, wdata:32'h0,        sdata:32'hDEADBE3C};
        vecs[2] = '{rw:1'b0, addr:7'h00, len:2'd3, wdata:32'h44332211, sdata:32'h0};
        vecs[3] = '{rw:1'b1, addr:7'h05, len:2'd3, wdata:32'h0,        sdata:32'h87654321};
        vecs[4] = '{rw:1'b0, addr:7'h2A, len:2'd1, wdata:32'hFFFFC35A, sdata:32'h0};
        vecs[5] = '{rw:1'b1, addr:7'h40, len:2'd2, wdata:32'h0,        sdata:32'h99A1B2C3};

        #23;
        chk("reset_csb", a_csb, 1);
        chk("reset_sclk", a_sclk, 0);
        chk("reset_oe", dut_a.oe, 0);
        chk("reset_ready", a_ready, 1);
        chk("reset_rsp_valid", a_rsp_valid, 0);
        chk("reset_rdata", a_rdata, 0);
        @(negedge clk); rstn = 1'b1;

        foreach (vecs[i]) begin
            issue(vecs[i], 1'b0);
            wait_idle();
        end

        // Back-to-back writes with cmd_valid held high.
        f0 = frames; r0 = rsps;
        v = '{rw:1'b0, addr:7'h11, len:2'd0, wdata:32'h0000005A, sdata:32'h0};
        issue(v, 1'b1);
        @(negedge clk); @(negedge clk);
        btb_mode = 1;
        v = '{rw:1'b0, addr:7'h12, len:2'd1, wdata:32'h0000C33C, sdata:32'h0};
        issue(v, 1'b0);
        wait_idle();
        btb_mode = 0;
        chk("btb_frames", frames - f0, 2);
        chk("btb_rsps", rsps - r0, 2);

        // Reset during bit 5 of a write.
        v = '{rw:1'b0, addr:7'h33, len:2'd1, wdata:32'h00001234, sdata:32'h0};
        issue(v, 1'b0);
        n = 0;
        while (s_falls < 5 && n < 500) begin @(negedge clk); n++; end
        chk("reset_mid_reached_bit5", s_falls, 5);
        #2 rstn = 1'b0;
        #1;
        chk("mid_reset_csb", a_csb, 1);
        chk("mid_reset_sclk", a_sclk, 0);
        chk("mid_reset_oe", dut_a.oe, 0);
        chk("mid_reset_sdio", a_sdio, 1);
        chk("mid_reset_ready", a_ready, 1);
        chk("mid_reset_rsp_valid", a_rsp_valid, 0);
        sb.delete();
        last_rdata = 0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        v = '{rw:1'b1, addr:7'h7F, len:2'd0, wdata:32'h0, sdata:32'h0000005A};
        issue(v, 1'b0);
        wait_idle();

        // 4-wire read of two bytes.
        @(negedge clk);
        b_rw = 1'b1; b_addr = 7'h12; b_len = 2'd1; b_valid = 1'b1;
        n = 0;
        while (!b_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1 b_valid = 1'b0;
        n = 0;
        while (!b_rsp_valid && n < 1000) begin @(negedge clk); n++; end
        chk("b_rsp_seen", b_rsp_valid, 1);
        chk("b_rsp_rdata", b_rdata, 32'h0000EFBE);
        chk("b_sclk_rises", b_rises, 24);
        chk("b_instr", (b_rx >> 16) & 64'hFF, 64'h92);
        chk("b_sdio_data_bits", b_rx & 64'hFFFF, 0);
        chk("b_sdio_not_zero_cycles", b_bad, 0);
        repeat (15) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected completion within 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
